// File: rtl/dom_pkg.sv
// Shared constants, FSM encoding and helpers for the DOM Z-mask generator.
// The LFSR polynomial is x^64+x^63+x^61+x^60+1.
package dom_pkg;

  localparam int LFSR_W = 64;

  // Feedback taps: bits 63, 62, 60, 59.
  localparam logic [LFSR_W-1:0] TAPS = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    ST_SEED,
    ST_WARM,
    ST_RUN
  } fsm_t;

  function automatic int zw(input int shares, input int nmul);
    return nmul * shares * (shares - 1);
  endfunction

endpackage

// File: rtl/dom_lfsr_adv.sv
// Combinational advance of the 64-bit Fibonacci LFSR by STEPS single steps.
// The newest feedback bit enters at bit 0.
module dom_lfsr_adv
  import dom_pkg::*;
#(
  parameter int STEPS = 1
) (
  input  logic [LFSR_W-1:0] StatexD,
  output logic [LFSR_W-1:0] NextxD
);

  always_comb begin
    NextxD = StatexD;
    for (int i = 0; i < STEPS; i++) begin
      NextxD = {NextxD[LFSR_W-2:0], ^(NextxD & TAPS)};
    end
  end

endmodule

// File: rtl/dom_zmask_gen.sv
// Fresh remask (Z) source for the shared GF(2^2) multipliers of the DOM S-box.
// Seeded LFSR with warm-up; Z is flagged valid only after a full seed and warm-up.
module dom_zmask_gen
  import dom_pkg::*;
#(
  parameter  int SHARES = 2,
  parameter  int NMUL   = 3,
  parameter  int SEED_W = 16,
  parameter  int WARM   = 8,
  localparam int ZW     = zw(SHARES, NMUL)
) (
  input  logic              ClkxCI,
  input  logic              RstxBI,
  input  logic [SEED_W-1:0] SeedxDI,
  input  logic              SeedValidxSI,
  output logic              SeedReadyxSO,
  input  logic              ReseedxSI,
  input  logic              EnxSI,
  output logic [ZW-1:0]     ZxDO,
  output logic              ZValidxSO
);

  localparam int NWORDS = LFSR_W / SEED_W;
  localparam int WCW    = $clog2(NWORDS) + 1;
  localparam int MCW    = $clog2(WARM) + 1;

  if (LFSR_W % SEED_W != 0) begin : gBadSeedW
    $error("SEED_W must divide 64");
  end
  if (ZW > LFSR_W || ZW < 1) begin : gBadZw
    $error("ZW must be within 1..64");
  end
  if (WARM < 1) begin : gBadWarm
    $error("WARM must be at least 1");
  end

  fsm_t              StatexDP;
  logic [WCW-1:0]    WordCntxDP;
  logic [MCW-1:0]    WarmCntxDP;
  logic [LFSR_W-1:0] LfsrxDP;
  logic [LFSR_W-1:0] LfsrAdvxD;
  logic [LFSR_W-1:0] LfsrLoadxD;
  logic [ZW-1:0]     ZxDP;
  logic              ZValidxSP;

  dom_lfsr_adv #(
    .STEPS(ZW)
  ) i_adv (
    .StatexD(LfsrxDP),
    .NextxD (LfsrAdvxD)
  );

  // New word enters at the bottom, oldest bits fall off the top.
  assign LfsrLoadxD = LFSR_W'({LfsrxDP, SeedxDI});

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      StatexDP   <= ST_SEED;
      WordCntxDP <= '0;
      WarmCntxDP <= '0;
      LfsrxDP    <= '0;
      ZxDP       <= '0;
      ZValidxSP  <= 1'b0;
    end else if (ReseedxSI) begin
      StatexDP   <= ST_SEED;
      WordCntxDP <= '0;
      WarmCntxDP <= '0;
      ZxDP       <= '0;
      ZValidxSP  <= 1'b0;
    end else begin
      unique case (StatexDP)
        ST_SEED: begin
          if (SeedValidxSI) begin
            if (WordCntxDP == WCW'(NWORDS - 1)) begin
              // An all-zero state would lock the LFSR forever.
              LfsrxDP    <= (LfsrLoadxD == '0) ? LFSR_W'(1) : LfsrLoadxD;
              WordCntxDP <= '0;
              WarmCntxDP <= '0;
              StatexDP   <= ST_WARM;
            end else begin
              LfsrxDP    <= LfsrLoadxD;
              WordCntxDP <= WordCntxDP + 1'b1;
            end
          end
        end
        ST_WARM: begin
          LfsrxDP <= LfsrAdvxD;
          if (WarmCntxDP == MCW'(WARM - 1)) begin
            StatexDP  <= ST_RUN;
            ZxDP      <= LfsrAdvxD[ZW-1:0];
            ZValidxSP <= 1'b1;
          end else begin
            WarmCntxDP <= WarmCntxDP + 1'b1;
          end
        end
        ST_RUN: begin
          if (EnxSI) begin
            LfsrxDP <= LfsrAdvxD;
            ZxDP    <= LfsrAdvxD[ZW-1:0];
          end
        end
        default: StatexDP <= ST_SEED;
      endcase
    end
  end

  assign SeedReadyxSO = (StatexDP == ST_SEED);
  assign ZxDO         = ZxDP;
  assign ZValidxSO    = ZValidxSP;

endmodule

// File: tb/tb_dom_zmask_gen.sv
// Bench for dom_zmask_gen: seed tables, corner sequences and random runs
// checked against a polynomial-level LFSR model.
module tb_dom_zmask_gen;

  localparam int ZW = 6;

  logic          ClkxCI = 1'b0;
  logic          RstxBI = 1'b0;
  logic [15:0]   SeedxDI = '0;
  logic          SeedValidxSI = 1'b0;
  logic          SeedReadyxSO;
  logic          ReseedxSI = 1'b0;
  logic          EnxSI = 1'b0;
  logic [ZW-1:0] ZxDO;
  logic          ZValidxSO;

  dom_zmask_gen #(
    .SHARES(2),
    .NMUL  (3),
    .SEED_W(16),
    .WARM  (8)
  ) dut (
    .ClkxCI      (ClkxCI),
    .RstxBI      (RstxBI),
    .SeedxDI     (SeedxDI),
    .SeedValidxSI(SeedValidxSI),
    .SeedReadyxSO(SeedReadyxSO),
    .ReseedxSI   (ReseedxSI),
    .EnxSI       (EnxSI),
    .ZxDO        (ZxDO),
    .ZValidxSO   (ZValidxSO)
  );

  always #5 ClkxCI = ~ClkxCI;

  int nChecks = 0;
  int nErrors = 0;
  logic [63:0] m = '0;
  bit seenNz;

  typedef struct {
    logic [0:3][15:0] w;
    logic [6:0]       z0;
    int               runN;
  } vec_t;

  vec_t tbl[4];

  // One step of x^64+x^63+x^61+x^60+1: term x^k reads bit k-1.
  function automatic logic [63:0] mStep(input logic [63:0] s);
    logic fb;
    fb = s[64-1] ^ s[63-1] ^ s[61-1] ^ s[60-1];
    return {s[62:0], fb};
  endfunction

  function automatic logic [63:0] mAdv(input logic [63:0] s);
    logic [63:0] r;
    r = s;
    for (int i = 0; i < ZW; i++) r = mStep(r);
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge ClkxCI);
    #1;
  endtask

  task automatic seedWords(input logic [0:3][15:0] w);
    for (int i = 0; i < 4; i++) begin
      SeedxDI = w[i];
      SeedValidxSI = 1'b1;
      chk("seed_ready", 64'(SeedReadyxSO), 64'd1);
      chk("seed_zvalid", 64'(ZValidxSO), 64'd0);
      tick();
      m = {m[47:0], w[i]};
    end
    SeedValidxSI = 1'b0;
    if (m == 64'd0) m = 64'd1;
  endtask

  task automatic warmup(input bit noise);
    for (int i = 1; i <= 8; i++) begin
      SeedValidxSI = noise ? 1'($urandom) : 1'b0;
      EnxSI = noise ? 1'($urandom) : 1'b0;
      SeedxDI = 16'($urandom);
      tick();
      m = mAdv(m);
      chk("warm_ready", 64'(SeedReadyxSO), 64'd0);
      if (i < 8) begin
        chk("warm_zvalid", 64'(ZValidxSO), 64'd0);
        chk("warm_z", 64'(ZxDO), 64'd0);
      end else begin
        chk("zvalid_rise", 64'(ZValidxSO), 64'd1);
        chk("z_first", 64'(ZxDO), 64'(m[ZW-1:0]));
      end
    end
    SeedValidxSI = 1'b0;
    EnxSI = 1'b0;
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      EnxSI = rnd ? 1'($urandom) : 1'b1;
      SeedValidxSI = rnd ? 1'($urandom) : 1'b0;
      SeedxDI = 16'($urandom);
      tick();
      if (EnxSI) m = mAdv(m);
      chk("run_zvalid", 64'(ZValidxSO), 64'd1);
      chk("run_z", 64'(ZxDO), 64'(m[ZW-1:0]));
      chk("run_ready", 64'(SeedReadyxSO), 64'd0);
      if (ZxDO != '0) seenNz = 1'b1;
    end
    EnxSI = 1'b0;
    SeedValidxSI = 1'b0;
  endtask

  task automatic reseed;
    ReseedxSI = 1'b1;
    tick();
    ReseedxSI = 1'b0;
    chk("reseed_zvalid", 64'(ZValidxSO), 64'd0);
    chk("reseed_z", 64'(ZxDO), 64'd0);
    chk("reseed_ready", 64'(SeedReadyxSO), 64'd1);
  endtask

  initial begin
    tbl[0].w = {16'h0001, 16'h0000, 16'h0000, 16'h0000};
    tbl[0].z0 = 7'h40;
    tbl[0].runN = 24;
    tbl[1].w = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
    tbl[1].z0 = 7'h40;
    tbl[1].runN = 24;
    tbl[2].w = {16'hDEAD, 16'hBEEF, 16'h1234, 16'h5678};
    tbl[2].z0 = 7'h00;
    tbl[2].runN = 16;
    tbl[3].w = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    tbl[3].z0 = 7'h00;
    tbl[3].runN = 16;

    #12;
    chk("rst_zvalid", 64'(ZValidxSO), 64'd0);
    chk("rst_z", 64'(ZxDO), 64'd0);
    @(negedge ClkxCI);
    RstxBI = 1'b1;
    tick();
    chk("rst_ready", 64'(SeedReadyxSO), 64'd1);

    // Seed table: warm-up timing, first Z, fresh Z under EnxSI.
    for (int v = 0; v < 4; v++) begin
      seedWords(tbl[v].w);
      warmup(1'b0);
      if (tbl[v].z0[6]) chk("z0_table", 64'(ZxDO), 64'(tbl[v].z0[5:0]));
      seenNz = 1'b0;
      run(tbl[v].runN, 1'b0);
      chk("z_not_stuck", 64'(seenNz), 64'd1);
      if (v == 0) begin
        EnxSI = 1'b0;
        for (int i = 0; i < 5; i++) begin
          tick();
          chk("hold_z", 64'(ZxDO), 64'(m[ZW-1:0]));
          chk("hold_zvalid", 64'(ZValidxSO), 64'd1);
        end
        run(8, 1'b0);
      end
      reseed();
    end

    // Reseed after 2 of 4 words: a full 4 words are needed afterwards.
    for (int i = 0; i < 2; i++) begin
      SeedxDI = 16'hA5A0 + 16'(i);
      SeedValidxSI = 1'b1;
      tick();
      m = {m[47:0], SeedxDI};
    end
    SeedValidxSI = 1'b0;
    reseed();
    seedWords({16'h0F0F, 16'h3C3C, 16'h0000, 16'h8001});
    warmup(1'b1);
    run(10, 1'b0);

    // Reseed with EnxSI and a seed handshake in the same cycle.
    ReseedxSI = 1'b1;
    EnxSI = 1'b1;
    SeedValidxSI = 1'b1;
    SeedxDI = 16'hBEEF;
    tick();
    ReseedxSI = 1'b0;
    EnxSI = 1'b0;
    SeedValidxSI = 1'b0;
    chk("rs5_zvalid", 64'(ZValidxSO), 64'd0);
    chk("rs5_z", 64'(ZxDO), 64'd0);
    chk("rs5_ready", 64'(SeedReadyxSO), 64'd1);
    seedWords({16'h1111, 16'h2222, 16'h3333, 16'h4444});
    warmup(1'b0);
    run(6, 1'b0);

    // Asynchronous reset mid-RUN, then mid-WARM.
    #2;
    RstxBI = 1'b0;
    #1;
    chk("arst_run_zvalid", 64'(ZValidxSO), 64'd0);
    chk("arst_run_z", 64'(ZxDO), 64'd0);
    chk("arst_run_ready", 64'(SeedReadyxSO), 64'd1);
    @(posedge ClkxCI);
    #2;
    RstxBI = 1'b1;
    m = '0;
    tick();
    seedWords({16'h0000, 16'h0000, 16'h00C3, 16'h0000});
    for (int i = 0; i < 3; i++) tick();
    #2;
    RstxBI = 1'b0;
    #1;
    chk("arst_warm_zvalid", 64'(ZValidxSO), 64'd0);
    chk("arst_warm_z", 64'(ZxDO), 64'd0);
    @(posedge ClkxCI);
    #2;
    RstxBI = 1'b1;
    #1;
    chk("arst_rel_ready", 64'(SeedReadyxSO), 64'd1);
    m = '0;
    tick();
    chk("arst_idle_zvalid", 64'(ZValidxSO), 64'd0);
    seedWords({16'h7777, 16'h0000, 16'h0000, 16'h0001});
    warmup(1'b0);
    run(6, 1'b0);
    reseed();

    // Random seeds, random EnxSI and ignored seed traffic.
    for (int r = 0; r < 8; r++) begin
      logic [0:3][15:0] w;
      for (int i = 0; i < 4; i++) begin
        w[i] = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      end
      seedWords(w);
      warmup(1'b1);
      run(30, 1'b1);
      reseed();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

endmodule
